exp_sched: RTL and testbench
============================

// Module: exp_sched
// PURPOSE
//  Shares one expunit (fp16 exp datapath, 1 registered stage) among NUM_REQ softmax lanes.
//  - Round-robin arbitration with burst lock.
//  - Drives expunit a/stage_run and tracks a valid+id shadow of the expunit pipeline register.
//  - Returns each result to the owning lane over a valid/ready response port.
//  - Sits between the per-lane subtract-from-max stage and the accumulate/divide stage.
// PARAMETERS
//  NUM_REQ    4   number of requesting lanes (2..8)
//  ID_W       2   width of lane id, = clog2(NUM_REQ)
//  MAX_BURST  8   max consecutive beats granted to one lane before forced rotation (1..255)
// PORTS
//  clk             in   1           clock
//  reset           in   1           asynchronous, active-low reset
//  req_valid       in   NUM_REQ     lane i has an fp16 operand
//  req_last        in   NUM_REQ     lane i's current beat is last of its vector
//  req_data        in   NUM_REQ*16  lane i operand at [16*i+15:16*i]
//  req_ready       out  NUM_REQ     operand of lane i accepted this cycle (one-hot or 0)
//  exp_a           out  16          operand to expunit a
//  exp_stage_run   out  1           expunit stage_run
//  exp_z           in   16          expunit z (valid one cycle after a run capture)
//  exp_status      in   8           expunit status
//  rsp_valid       out  1           result available
//  rsp_data        out  16          = exp_z
//  rsp_status      out  8           = exp_status
//  rsp_id          out  ID_W        lane owning rsp_data
//  rsp_last        out  1           result is last beat of that lane's vector
//  rsp_ready       in   1           consumer accepts result
//  busy            out  1           pipe_v | any req_valid
// BEHAVIOUR
//  Reset (async, reset=0)
//   - pipe_v=0, pipe_id=0, pipe_last=0, owner=0, locked=0, beat_cnt=0, rr_ptr=0.
//   - Outputs: req_ready=0, exp_stage_run=0, rsp_valid=0, rsp_id=0, rsp_last=0, busy=0.
//   - exp_a=0 combinationally.
//  Advance
//   - adv = !pipe_v | rsp_ready.
//   - exp_stage_run = adv. It must be 0 whenever pipe_v=1 and rsp_ready=0, so expunit regs hold.
//  Grant
//   - Combinational, evaluated only when adv=1.
//   - locked=1 and req_valid[owner]=1: grant owner.
//   - locked=1 and req_valid[owner]=0: lane stalls mid-vector; no grant, lock kept, bubble.
//   - locked=0: first lane with req_valid set, searching rr_ptr, rr_ptr+1 ... (mod NUM_REQ).
//   - req_ready[g]=1 only for granted lane g.
//   - exp_a = req_data[g] when granted, else 0.
//  Issue (edge with adv=1)
//   - pipe_v <= grant_any; pipe_id <= g; pipe_last <= req_last[g].
//   - adv=1 with no grant loads a bubble (pipe_v <= 0).
//  Burst (on each issued beat)
//   - beat_cnt <= beat_cnt+1; locked <= 1; owner <= g.
//   - Release when req_last[g]=1 or beat_cnt+1 == MAX_BURST:
//     locked <= 0, beat_cnt <= 0, rr_ptr <= (g+1) mod NUM_REQ.
//   - A forced release mid-vector is legal; the lane re-arbitrates.
//  Response
//   - rsp_valid = pipe_v; rsp_id = pipe_id; rsp_last = pipe_last.
//   - rsp_data/rsp_status pass through from expunit.
//   - Result leaves on rsp_valid & rsp_ready.
//   - Back-to-back: with rsp_ready held 1 and operands always present, one result per cycle.
//   - Latency: operand accept edge -> rsp_valid next cycle (1 cycle).
//  Boundaries
//   - Stall: rsp_ready=0 with pipe_v=1 holds rsp_* stable, all req_ready=0, stage_run=0.
//   - Simultaneous: pop of the held result and a new grant on the same edge is required.
//   - Wrap: rr_ptr wraps NUM_REQ-1 -> 0.
//   - Rotation: a single active lane regrants itself after a forced release.
//   - Mid-operation reset: in-flight result is dropped and rsp_valid=0 immediately.
//     The expunit's own reset is driven by the integrator.
//   - req_data of non-granted lanes never reaches exp_a.
// TESTING
//  1. Reset: hold reset=0 with all req_valid=1 -> req_ready=0, exp_stage_run=0, rsp_valid=0;
//     release -> lane 0 granted on the first edge.
//  2. Single lane: lane 2 sends 3 beats (0xBC00, 0xC000, 0x0000), last on the 3rd, rsp_ready=1.
//     -> rsp_id=2 on 3 consecutive cycles, each one cycle after its accept.
//     -> rsp_last=1 on the 3rd; data matches expunit z.
//  3. Burst cap: MAX_BURST=8, lanes 0 and 1 stream 20 beats each, no last.
//     -> grant order 0x8, 1x8, 0x8, 1x8, 0x4, 1x4; rr_ptr wraps.
//  4. Backpressure: drop rsp_ready for 5 cycles mid-stream.
//     -> rsp_data/rsp_id frozen, exp_stage_run=0, no req_ready.
//     -> resume with no lost or duplicated beat, order preserved.
//  5. Lock bubble: lane 1 locked and drops req_valid for 2 cycles while lane 3 is valid.
//     -> no grant to lane 3; 2 bubbles (rsp_valid=0); lane 1 resumes.
//  6. Mid-operation reset: reset=0 while pipe_v=1 and rsp_ready=0.
//     -> rsp_valid falls the same cycle; after release, lane 0 wins arbitration.

Source files
------------

// File: rtl/exp_sched.sv
// Shares one single-stage fp16 exp unit among NUM_REQ softmax lanes.
// The lanes are arbitrated round-robin, and a granted lane keeps the unit for a burst until its vector ends or the burst cap is reached.
module exp_sched #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_last,
    input  logic [NUM_REQ*16-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [15:0]             exp_a,
    output logic                    exp_stage_run,
    input  logic [15:0]             exp_z,
    input  logic [7:0]              exp_status,
    output logic                    rsp_valid,
    output logic [15:0]             rsp_data,
    output logic [7:0]              rsp_status,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_last,
    input  logic                    rsp_ready,
    output logic                    busy
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = ID_W + 1;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               pipe_v_q, pipe_v_d;
    logic [ID_W-1:0]    pipe_id_q, pipe_id_d;
    logic               pipe_last_q, pipe_last_d;

    logic               adv;
    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W:0]     beat_next;
    logic               release_burst;

    // The pipe may move only when its current result can leave. In reset nothing moves.
    assign adv           = reset & (~pipe_v_q | rsp_ready);
    assign exp_stage_run = adv;

    // Grant selection. A locked owner never yields to another lane, even when it stalls.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        if (adv) begin
            if (state_q == ST_BURST) begin
                if (req_valid[owner_q]) begin
                    grant_any = 1'b1;
                    grant_id  = owner_q;
                end
            end else begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    idx = IDX_W'(rr_ptr_q) + IDX_W'(k);
                    if (idx >= IDX_W'(NUM_REQ)) begin
                        idx = idx - IDX_W'(NUM_REQ);
                    end
                    if (!grant_any && req_valid[ID_W'(idx)]) begin
                        grant_any = 1'b1;
                        grant_id  = ID_W'(idx);
                    end
                end
            end
        end
    end

    // Only the granted lane's operand is steered to the exp unit.
    always_comb begin
        req_ready = '0;
        exp_a     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_any && (grant_id == ID_W'(k))) begin
                req_ready[k] = 1'b1;
                exp_a        = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state for the burst lock, the rotation pointer and the pipe shadow.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        pipe_v_d      = pipe_v_q;
        pipe_id_d     = pipe_id_q;
        pipe_last_d   = pipe_last_q;
        beat_next     = {1'b0, beat_cnt_q} + (CNT_W+1)'(1);
        release_burst = req_last[grant_id] || (beat_next == (CNT_W+1)'(MAX_BURST));

        if (adv) begin
            pipe_v_d    = grant_any;
            pipe_id_d   = grant_id;
            pipe_last_d = grant_any & req_last[grant_id];
        end

        if (grant_any) begin
            owner_d = grant_id;
            if (release_burst) begin
                state_d    = ST_ARB;
                beat_cnt_d = '0;
                rr_ptr_d   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end else begin
                state_d    = ST_BURST;
                beat_cnt_d = beat_next[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_ARB;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            pipe_v_q    <= 1'b0;
            pipe_id_q   <= '0;
            pipe_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            pipe_v_q    <= pipe_v_d;
            pipe_id_q   <= pipe_id_d;
            pipe_last_q <= pipe_last_d;
        end
    end

    assign rsp_valid  = pipe_v_q;
    assign rsp_id     = pipe_id_q;
    assign rsp_last   = pipe_last_q;
    assign rsp_data   = exp_z;
    assign rsp_status = exp_status;
    assign busy       = reset & (pipe_v_q | (|req_valid));

endmodule

// File: tb/tb_exp_sched.sv
// Bench for exp_sched. It includes a small expunit stub and a scoreboard model of arbitration and responses.
module tb_exp_sched;

    localparam int unsigned N    = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned MAXB = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid, req_last, req_ready;
    logic [N*16-1:0]    req_data;
    logic [15:0]        exp_a;
    logic               exp_stage_run;
    logic [15:0]        exp_z = '0;
    logic [7:0]         exp_status = '0;
    logic               rsp_valid, rsp_last, rsp_ready, busy;
    logic [15:0]        rsp_data;
    logic [7:0]         rsp_status;
    logic [IDW-1:0]     rsp_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        bit          last;
        logic [15:0] data;
        logic [7:0]  st;
    } rsp_t;

    typedef struct {
        logic [N-1:0] valid;
        logic         rdy;
        logic [N-1:0] want_ready;
        logic         want_rsp_valid;
    } vec_t;

    rsp_t pend[$];
    int   grant_log[$];
    bit   m_locked;
    int   m_owner, m_cnt, m_rr;
    int   model_g, dut_grant;
    bit   model_pop;

    exp_sched #(.NUM_REQ(N), .ID_W(IDW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .exp_a(exp_a), .exp_stage_run(exp_stage_run),
        .exp_z(exp_z), .exp_status(exp_status),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .rsp_id(rsp_id), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    function automatic logic [7:0] st_fn(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h81;
    endfunction

    // Expunit stand-in: one register stage that captures exp_a on stage_run.
    always @(posedge clk) begin
        if (exp_stage_run) begin
            exp_z      <= exp_fn(exp_a);
            exp_status <= st_fn(exp_a);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_locked = 1'b0;
        m_owner  = 0;
        m_cnt    = 0;
        m_rr     = 0;
    endtask

    // Settle inputs, then compare every DUT output with what the model expects this cycle.
    task automatic sample_and_check();
        bit           full, adv;
        logic [N-1:0] want_rdy;
        logic [15:0]  want_a;
        #1;
        dut_grant = -1;
        for (int i = 0; i < int'(N); i++) if (req_ready[i]) dut_grant = i;
        model_g   = -1;
        model_pop = 1'b0;
        if (!reset) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_stage_run", 32'(exp_stage_run), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_exp_a", 32'(exp_a), 32'd0);
            model_reset();
        end else begin
            full = (pend.size() != 0);
            adv  = !full || rsp_ready;
            if (adv) begin
                if (m_locked) begin
                    if (req_valid[m_owner]) model_g = m_owner;
                end else begin
                    for (int k = 0; k < int'(N); k++) begin
                        if (model_g < 0 && req_valid[(m_rr + k) % int'(N)]) model_g = (m_rr + k) % int'(N);
                    end
                end
            end
            want_rdy = '0;
            want_a   = '0;
            if (model_g >= 0) begin
                want_rdy[model_g] = 1'b1;
                want_a = req_data[model_g*16 +: 16];
            end
            chk("req_ready", 32'(req_ready), 32'(want_rdy));
            chk("stage_run", 32'(exp_stage_run), 32'(adv));
            chk("exp_a", 32'(exp_a), 32'(want_a));
            chk("rsp_valid", 32'(rsp_valid), 32'(full));
            chk("busy", 32'(busy), 32'(full || (|req_valid)));
            if (full) begin
                chk("rsp_id", 32'(rsp_id), 32'(pend[0].id));
                chk("rsp_last", 32'(rsp_last), 32'(pend[0].last));
                chk("rsp_data", 32'(rsp_data), 32'(pend[0].data));
                chk("rsp_status", 32'(rsp_status), 32'(pend[0].st));
            end
            model_pop = full && rsp_ready;
        end
    endtask

    // Apply the clock edge to the model, then move to the next falling edge.
    task automatic advance();
        rsp_t r;
        if (model_pop) void'(pend.pop_front());
        if (model_g >= 0) begin
            r.id   = model_g;
            r.last = req_last[model_g];
            r.data = exp_fn(req_data[model_g*16 +: 16]);
            r.st   = st_fn(req_data[model_g*16 +: 16]);
            pend.push_back(r);
            m_cnt++;
            if (req_last[model_g] || m_cnt == int'(MAXB)) begin
                m_locked = 1'b0;
                m_cnt    = 0;
                m_rr     = (model_g + 1) % int'(N);
            end else begin
                m_locked = 1'b1;
                m_owner  = model_g;
            end
        end
        if (dut_grant >= 0) grant_log.push_back(dut_grant);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step();
        sample_and_check();
        advance();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        rsp_ready = 1'b1;
        step();
        reset = 1'b1;
    endtask

    task automatic rand_data();
        req_data = {$urandom, $urandom};
    endtask

    vec_t tbl[10];
    int   rem[2];
    int   want_log[$];
    logic [15:0] frz_data;
    int          frz_id;

    initial begin
        reset     = 1'b0;
        req_valid = '1;
        req_last  = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0};
        tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[2] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
        tbl[3] = '{4'b1000, 1'b1, 4'b1000, 1'b1};
        tbl[4] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
        tbl[5] = '{4'b0110, 1'b1, 4'b0010, 1'b0};
        tbl[6] = '{4'b0110, 1'b1, 4'b0100, 1'b1};
        tbl[7] = '{4'b0011, 1'b1, 4'b0001, 1'b1};
        tbl[8] = '{4'b1111, 1'b0, 4'b0000, 1'b1};
        tbl[9] = '{4'b1111, 1'b1, 4'b0010, 1'b1};
        model_reset();
        @(negedge clk);

        // Reset held with every lane requesting, then released.
        for (int i = 0; i < 2; i++) begin
            rand_data();
            step();
        end
        reset = 1'b1;
        rand_data();
        sample_and_check();
        chk("reset_first_grant", 32'(req_ready), 32'h1);
        advance();

        // Arbitration table. Every beat is a last beat, so the pointer rotates after each grant.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].valid;
            req_last  = '1;
            rsp_ready = tbl[i].rdy;
            rand_data();
            sample_and_check();
            chk("tbl_req_ready", 32'(req_ready), 32'(tbl[i].want_ready));
            chk("tbl_rsp_valid", 32'(rsp_valid), 32'(tbl[i].want_rsp_valid));
            advance();
        end

        // Single lane, three beats.
        do_reset();
        req_data  = '0;
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data[2*16 +: 16] = 16'hBC00;
        sample_and_check();
        chk("single_accept0", 32'(req_ready), 32'h4);
        advance();
        req_data[2*16 +: 16] = 16'hC000;
        sample_and_check();
        chk("single_id0", 32'(rsp_id), 32'd2);
        chk("single_data0", 32'(rsp_data), 32'(exp_fn(16'hBC00)));
        advance();
        req_data[2*16 +: 16] = 16'h0000;
        req_last  = 4'b0100;
        sample_and_check();
        chk("single_id1", 32'(rsp_id), 32'd2);
        chk("single_data1", 32'(rsp_data), 32'(exp_fn(16'hC000)));
        advance();
        req_valid = '0;
        req_last  = '0;
        sample_and_check();
        chk("single_id2", 32'(rsp_id), 32'd2);
        chk("single_last2", 32'(rsp_last), 32'd1);
        chk("single_data2", 32'(rsp_data), 32'(exp_fn(16'h0000)));
        advance();

        // Burst cap: two lanes with 20 beats each. Only the final beat of each lane is marked last.
        do_reset();
        grant_log.delete();
        rem[0] = 20;
        rem[1] = 20;
        for (int cyc = 0; cyc < 200 && (rem[0] > 0 || rem[1] > 0); cyc++) begin
            req_valid = {2'b00, rem[1] > 0, rem[0] > 0};
            req_last  = {2'b00, rem[1] == 1, rem[0] == 1};
            rand_data();
            step();
            if (dut_grant == 0 || dut_grant == 1) rem[dut_grant]--;
        end
        chk("burst_done", 32'(rem[0] + rem[1]), 32'd0);
        want_log.delete();
        for (int i = 0; i < 8; i++) want_log.push_back(0);
        for (int i = 0; i < 8; i++) want_log.push_back(1);
        for (int i = 0; i < 8; i++) want_log.push_back(0);
        for (int i = 0; i < 8; i++) want_log.push_back(1);
        for (int i = 0; i < 4; i++) want_log.push_back(0);
        for (int i = 0; i < 4; i++) want_log.push_back(1);
        chk("burst_len", 32'(grant_log.size()), 32'd40);
        for (int i = 0; i < 40 && i < grant_log.size(); i++) begin
            chk("burst_order", 32'(grant_log[i]), 32'(want_log[i]));
        end

        // Backpressure mid-stream.
        req_last = '0;
        for (int i = 0; i < 6; i++) begin
            req_valid = '1;
            rsp_ready = 1'b1;
            rand_data();
            step();
        end
        frz_data = pend.size() != 0 ? pend[0].data : 16'h0;
        frz_id   = pend.size() != 0 ? pend[0].id : 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            sample_and_check();
            chk("stall_data", 32'(rsp_data), 32'(frz_data));
            chk("stall_id", 32'(rsp_id), 32'(frz_id));
            chk("stall_run", 32'(exp_stage_run), 32'd0);
            chk("stall_ready", 32'(req_ready), 32'd0);
            advance();
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_data();
            step();
        end

        // Lock bubble: lane 1 stalls mid-vector while lane 3 is waiting.
        do_reset();
        req_last  = '0;
        req_valid = 4'b0010;
        rand_data();
        step();
        rand_data();
        step();
        req_valid = 4'b1000;
        rand_data();
        sample_and_check();
        chk("bubble_ready0", 32'(req_ready), 32'd0);
        chk("bubble_rv0", 32'(rsp_valid), 32'd1);
        advance();
        rand_data();
        sample_and_check();
        chk("bubble_ready1", 32'(req_ready), 32'd0);
        chk("bubble_rv1", 32'(rsp_valid), 32'd0);
        advance();
        req_valid = 4'b1010;
        req_last  = 4'b0010;
        rand_data();
        sample_and_check();
        chk("bubble_resume", 32'(req_ready), 32'h2);
        chk("bubble_rv2", 32'(rsp_valid), 32'd0);
        advance();
        req_valid = 4'b1000;
        req_last  = 4'b0000;
        rand_data();
        sample_and_check();
        chk("bubble_next", 32'(req_ready), 32'h8);
        chk("bubble_last_id", 32'(rsp_id), 32'd1);
        advance();

        // Reset asserted while a result is held under backpressure.
        do_reset();
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        rsp_ready = 1'b1;
        rand_data();
        step();
        req_valid = '1;
        req_last  = '0;
        rsp_ready = 1'b0;
        rand_data();
        step();
        reset = 1'b0;
        sample_and_check();
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        advance();
        reset     = 1'b1;
        rsp_ready = 1'b1;
        sample_and_check();
        chk("midrst_grant", 32'(req_ready), 32'h1);
        advance();

        // Random traffic checked against the model.
        for (int i = 0; i < 600; i++) begin
            req_valid = N'($urandom);
            req_last  = N'($urandom) & N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            step();
        end

        // Drain. Keep lanes idle until every pending result has left.
        req_valid = '0;
        req_last  = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        #1;
        chk("drain_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
